layer_output_pixel_buffer: RTL
==============================

// Module: layer_output_pixel_buffer
// PURPOSE
// - Storage between a layer's output side and the next layer's pixel fetch.
// - Write port: accepts (save_enable, output_row, output_col, output_data) from the maxpooling/conv producer.
// - Read port: answers (read_pixel_signal, read_row_addr, read_col_addr) from the consumer; raises pixel_store_done once the map is complete.
// PARAMETERS
// - ROWS    14   output map height (entries)
// - COLS    14   output map width (entries)
// - DATA_W  128  pixel word width: 8 channels x 16 bit
// - ADDR_W  16   row/col address width (matches `WORDLENGTH)
// PORTS
// - clk                    in   1       clock
// - rst                    in   1       synchronous, active-high reset
// - save_enable            in   1       write strobe from producer
// - output_row             in   ADDR_W  write row
// - output_col             in   ADDR_W  write column
// - output_data            in   DATA_W  write data
// - layer_calculation_done in   1       producer finished the map (1-cycle pulse)
// - next_layer_done        in   1       consumer finished reading; release the buffer (pulse)
// - read_pixel_signal      in   1       read request
// - read_row_addr          in   ADDR_W  read row
// - read_col_addr          in   ADDR_W  read column
// - pixel_store_done       out  1       level: map complete, reads serviced
// - read_data              out  DATA_W  read data
// - read_valid             out  1       read_data valid this cycle
// - write_count            out  ADDR_W  accepted writes since last release
// - addr_err               out  1       sticky: out-of-range write seen
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset:
//   - state=S_EMPTY; pixel_store_done=0, read_valid=0, read_data=0, write_count=0, addr_err=0.
//   - Memory contents are not cleared.
// - Memory index = row*COLS + col; depth ROWS*COLS.
// - S_EMPTY:
//   - save_enable: write accepted, go to S_FILL.
//   - layer_calculation_done with no write: go to S_FULL (empty map).
// - S_FILL:
//   - every in-range save_enable writes the entry and increments write_count.
//   - Go to S_FULL when layer_calculation_done=1 or write_count reaches ROWS*COLS.
//   - A write in the same cycle as done is still stored.
// - S_FULL:
//   - pixel_store_done=1; save_enable is ignored, no count change.
//   - next_layer_done: go to S_EMPTY, write_count=0, pixel_store_done falls the next cycle.
// - Out-of-range write (row>=ROWS or col>=COLS):
//   - dropped, addr_err set (sticky until reset), write_count unchanged.
// - Rewriting the same address overwrites the entry and still counts.
// - Reads: 1-cycle latency.
//   - read_pixel_signal at cycle N in S_FULL: read_data/read_valid at N+1.
//   - Back-to-back reads give one result per cycle.
//   - Read requests outside S_FULL: read_valid=0, read_data=0.
//   - A release on the same cycle as a read still returns that read's data.
// - Reset mid-operation returns to S_EMPTY immediately; an in-flight read is dropped (read_valid=0).
// CONFIGURATION
// - LAYER_BUF_ZERO_PAD_EN defined:
//   - a read with row or col out of range returns read_data=0 with read_valid=1.
//   - This gives the consumer's 3x3 conv its padding.
// - LAYER_BUF_ZERO_PAD_EN undefined:
//   - out-of-range reads return read_valid=1 with the data of index (row%ROWS)*COLS + (col%COLS).
// STRUCTURE
// - Shared package layer_buf_pkg:
//   - typedef pixel_t (DATA_W-bit)
//   - state enum {S_EMPTY, S_FILL, S_FULL}
//   - function idx(row, col)
// - One sub-module: pixel_buffer_ram (1 write port, 1 registered read port; synthesises to SRAM/regfile).
// - FSM, counter and address checks stay in the top.
// TESTING
// - Fill all 196 entries, value = {8{row*16+col}}, then done: pixel_store_done=1; read (5,7) -> read_data={8{16'h57}} one cycle later.
// - Write (14,0): dropped, addr_err=1, write_count unchanged.
// - Zero pad: with ZERO_PAD_EN, read (0xFFFF,3) -> 0, read_valid=1; without it, index wraps.
// - Write on the done cycle: done and write to (13,13) together; read (13,13) returns that data; later save_enable ignored.
// - Release: next_layer_done in S_FULL -> pixel_store_done=0 and write_count=0 next cycle; a read then gives read_valid=0.
// - rst asserted mid-fill at write_count=50 -> all outputs at reset values the next cycle; a new fill starts cleanly.

Source files
------------

// File: rtl/layer_buf_pkg.sv
// Shared types, geometry and the row/col to memory index mapping for the layer output pixel buffer.
package layer_buf_pkg;

    localparam int ROWS   = 14;
    localparam int COLS   = 14;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = ROWS * COLS;
    localparam int MEM_AW = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } state_t;

    // Row-major linear index; callers guarantee row < ROWS and col < COLS.
    function automatic logic [MEM_AW-1:0] idx(input logic [ADDR_W-1:0] row,
                                              input logic [ADDR_W-1:0] col);
        return MEM_AW'(row * ADDR_W'(COLS) + col);
    endfunction

endpackage

// File: rtl/layer_output_pixel_buffer_if.sv
// Producer/consumer bus of the layer output pixel buffer; master is the layer side, slave the buffer.
interface layer_output_pixel_buffer_if;
    import layer_buf_pkg::*;

    logic              save_enable;
    logic [ADDR_W-1:0] output_row;
    logic [ADDR_W-1:0] output_col;
    pixel_t            output_data;
    logic              layer_calculation_done;
    logic              next_layer_done;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic              pixel_store_done;
    pixel_t            read_data;
    logic              read_valid;
    logic [ADDR_W-1:0] write_count;
    logic              addr_err;

    modport master (
        output save_enable, output_row, output_col, output_data,
               layer_calculation_done, next_layer_done,
               read_pixel_signal, read_row_addr, read_col_addr,
        input  pixel_store_done, read_data, read_valid, write_count, addr_err
    );

    modport slave (
        input  save_enable, output_row, output_col, output_data,
               layer_calculation_done, next_layer_done,
               read_pixel_signal, read_row_addr, read_col_addr,
        output pixel_store_done, read_data, read_valid, write_count, addr_err
    );

endinterface

// File: rtl/layer_output_pixel_buffer_ram.sv
// pixel_buffer_ram: one write port and one registered read port, written so it maps onto SRAM/regfile.
module pixel_buffer_ram
    import layer_buf_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  pixel_t            wdata_i,
    input  logic              re_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output pixel_t            rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    // No reset on storage or read register so the array stays a plain memory macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_output_pixel_buffer.sv
// layer_output_pixel_buffer: holds one layer's output map until the next layer has consumed it.
// Define LAYER_BUF_ZERO_PAD_EN to return zeros for out-of-range reads instead of wrapping the address.
module layer_output_pixel_buffer
    import layer_buf_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    layer_output_pixel_buffer_if.slave bus
);

    state_t            state_q;
    logic [ADDR_W-1:0] writeCount_q;
    logic              storeDone_q;
    logic              readValid_q;
    logic              readPad_q;
    logic              addrErr_q;

    logic              wrInRange;
    logic              wrAccept;
    logic              fillEnd;
    logic              ramRe;
    logic              rdPad;
    logic [ADDR_W-1:0] countInc;
    logic [MEM_AW-1:0] wrIdx;
    logic [MEM_AW-1:0] rdIdx;
    pixel_t            ramData;

    always_comb begin
        wrInRange = (bus.output_row < ADDR_W'(ROWS)) && (bus.output_col < ADDR_W'(COLS));
        wrAccept  = bus.save_enable && wrInRange && (state_q != S_FULL);
        countInc  = writeCount_q + ADDR_W'(1);
        fillEnd   = bus.layer_calculation_done || (wrAccept && (countInc == ADDR_W'(DEPTH)));
        wrIdx     = idx(bus.output_row, bus.output_col);
        // Wrapped index is always in range, so the RAM is never addressed past its depth.
        rdIdx     = idx(bus.read_row_addr % ADDR_W'(ROWS), bus.read_col_addr % ADDR_W'(COLS));
        ramRe     = bus.read_pixel_signal && (state_q == S_FULL);
`ifdef LAYER_BUF_ZERO_PAD_EN
        rdPad     = ramRe && ((bus.read_row_addr >= ADDR_W'(ROWS)) ||
                              (bus.read_col_addr >= ADDR_W'(COLS)));
`else
        rdPad     = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            writeCount_q <= '0;
            storeDone_q  <= 1'b0;
            readValid_q  <= 1'b0;
            readPad_q    <= 1'b0;
            addrErr_q    <= 1'b0;
        end else begin
            readValid_q <= ramRe;
            readPad_q   <= rdPad;
            if (bus.save_enable && !wrInRange && (state_q != S_FULL)) begin
                addrErr_q <= 1'b1;
            end
            case (state_q)
                S_EMPTY, S_FILL: begin
                    if (wrAccept) begin
                        writeCount_q <= countInc;
                    end
                    if (fillEnd) begin
                        state_q     <= S_FULL;
                        storeDone_q <= 1'b1;
                    end else if (bus.save_enable) begin
                        state_q <= S_FILL;
                    end
                end
                S_FULL: begin
                    if (bus.next_layer_done) begin
                        state_q      <= S_EMPTY;
                        writeCount_q <= '0;
                        storeDone_q  <= 1'b0;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    pixel_buffer_ram u_ram (
        .clk     (clk),
        .we_i    (wrAccept),
        .waddr_i (wrIdx),
        .wdata_i (bus.output_data),
        .re_i    (ramRe),
        .raddr_i (rdIdx),
        .rdata_o (ramData)
    );

    // The RAM read register holds stale data between reads, so gate it with the valid flag.
    assign bus.read_data        = (readValid_q && !readPad_q) ? ramData : '0;
    assign bus.read_valid       = readValid_q;
    assign bus.pixel_store_done = storeDone_q;
    assign bus.write_count      = writeCount_q;
    assign bus.addr_err         = addrErr_q;

endmodule
